pwm_mode_ctrl: RTL

Upstream control stage for the PWM pulse generator: turns two raw push-buttons into the 2-bit duty-cycle `mode` bus that the generator consumes. Synchronizes and debounces both buttons, steps a target mode up or down per press, and commits the target to `mode` only at a PWM frame boundary, so duty changes never truncate a period. Sits between board I/O and the pulse generator's `mode` input, in the same clock domain.

---
 rtl/pwm_mode_ctrl_if.sv | 25 ++
 rtl/pwm_mode_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm_mode_ctrl_if.sv
// Button inputs and committed-mode outputs of the PWM mode controller.
// The board/bench side uses master; the controller uses slave.
interface pwm_mode_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] mode;
    logic       mode_changed;
    logic       pending;

    modport master (
        output btn_up,
        output btn_down,
        input  mode,
        input  mode_changed,
        input  pending
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output mode,
        output mode_changed,
        output pending
    );
endinterface

// File: rtl/pwm_mode_ctrl.sv
// Button-driven duty mode stepper that commits only on PWM frame boundaries.
// Define MODE_WRAP_EN for wrapping steps; the default build saturates at 0 and 3.
module pwm_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_mode_ctrl_if.slave  bus
);

    localparam int unsigned   FW      = $clog2(PERIOD);
    localparam logic [15:0]   DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(PERIOD - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_e;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_dly_q, deb_dly_d;
    logic [1:0]       evt_q, evt_d;
    logic [1:0][15:0] cnt_q, cnt_d;

    logic [FW-1:0]    frame_q, frame_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       mode_q, mode_d;
    logic             mc_q, mc_d;
    logic             pend_q, pend_d;
    state_e           state_q, state_d;

    logic [1:0]       next_target;
    logic             boundary;
    logic             step_up;
    logic             step_dn;

    always_comb begin
        sync1_d   = {bus.btn_down, bus.btn_up};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
        deb_dly_d = deb_q;
        evt_d     = deb_q & ~deb_dly_q;
    end

    // Opposing presses in the same cycle cancel each other.
    always_comb begin
        step_up     = evt_q[0] & ~evt_q[1];
        step_dn     = evt_q[1] & ~evt_q[0];
        next_target = target_q;
        if (step_up) begin
`ifdef MODE_WRAP_EN
            next_target = target_q + 2'd1;
`else
            if (target_q != 2'd3) begin
                next_target = target_q + 2'd1;
            end
`endif
        end else if (step_dn) begin
`ifdef MODE_WRAP_EN
            next_target = target_q - 2'd1;
`else
            if (target_q != 2'd0) begin
                next_target = target_q - 2'd1;
            end
`endif
        end
    end

    always_comb begin
        boundary = (frame_q == FR_LAST);
        frame_d  = boundary ? '0 : frame_q + FW'(1);
    end

    // The commit edge is the frame wrap, matching the generator's period.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mc_d     = 1'b0;
        target_d = next_target;
        unique case (state_q)
            IDLE: begin
                if (next_target != mode_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    mode_d  = next_target;
                    mc_d    = (next_target != mode_q);
                    state_d = IDLE;
                end else if (next_target == mode_q) begin
                    state_d = IDLE;
                end
            end
        endcase
        pend_d = (state_d == PEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            evt_q     <= '0;
            cnt_q     <= '0;
            frame_q   <= '0;
            target_q  <= '0;
            mode_q    <= '0;
            mc_q      <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            evt_q     <= evt_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            target_q  <= target_d;
            mode_q    <= mode_d;
            mc_q      <= mc_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
        end
    end

    assign bus.mode         = mode_q;
    assign bus.mode_changed = mc_q;
    assign bus.pending      = pend_q;

endmodule
